// File: rtl/risc16_program_loader_pkg.sv
// Shared constants and state encoding for the RISC16 program loader.
package risc16_program_loader_pkg;

  localparam int unsigned DefWordLength = 16;
  localparam int unsigned DefAddrWidth  = 16;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StDone = 2'b10,
    StErr  = 2'b11
  } state_e;

endpackage

// File: rtl/risc16_program_loader.sv
// Streams instruction words into an external instruction memory while holding the CPU.
// Writes are registered one cycle after acceptance; overflow traps in a sticky error state.
module risc16_program_loader
  import risc16_program_loader_pkg::*;
#(
  parameter int unsigned WORD_LENGTH = DefWordLength,
  parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
  parameter int unsigned MEM_SIZE    = 65536
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pen,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic                   in_valid,
  input  logic [WORD_LENGTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   mem_wen,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]    word_count,
  output logic [WORD_LENGTH-1:0] checksum,
  output logic                   cpu_hold,
  output logic                   load_done,
  output logic                   load_err
);

  localparam logic [ADDR_WIDTH:0] MemSizeW = (ADDR_WIDTH + 1)'(MEM_SIZE);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]    count_q, count_d;
  logic [WORD_LENGTH-1:0] csum_q, csum_d;
  logic                   wen_q, wen_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [WORD_LENGTH-1:0] wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic                   pen_low_q, pen_low_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      count_q   <= '0;
      csum_q    <= '0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      pen_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      csum_q    <= csum_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      pen_low_q <= pen_low_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    csum_d    = csum_q;
    wen_d     = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    pen_low_d = pen_low_q;
    unique case (state_q)
      StIdle: begin
        if (pen) begin
          state_d = StLoad;
          ptr_d   = base_addr;
          count_d = '0;
          csum_d  = '0;
        end
      end
      StLoad: begin
        // Overflow wins over a simultaneous pen drop: the extra word is never written.
        if (in_valid && (count_q == MemSizeW)) begin
          state_d   = StErr;
          err_d     = 1'b1;
          pen_low_d = 1'b0;
        end else begin
          if (in_valid) begin
            wen_d   = 1'b1;
            addr_d  = ptr_q;
            wdata_d = in_data;
            ptr_d   = ptr_q + 1'b1;
            count_d = count_q + 1'b1;
            csum_d  = csum_q ^ in_data;
          end
          if (!pen) state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      StErr: begin
        // Leave only on a fresh pen rising edge seen after the error.
        if (!pen) begin
          pen_low_d = 1'b1;
        end else if (pen_low_q) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready   = (state_q == StLoad);
  assign cpu_hold   = (state_q != StIdle);
  assign load_done  = (state_q == StDone);
  assign load_err   = err_q;
  assign mem_wen    = wen_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_count = count_q;
  assign checksum   = csum_q;

endmodule

// File: tb/tb_risc16_program_loader.sv
// Directed bench for the program loader: a default-sized instance plus a small
// instance (4-bit address, 4-word memory) for wrap and overflow scenarios.
module tb_risc16_program_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance
  logic        pen, in_valid, in_ready, mem_wen, cpu_hold, load_done, load_err;
  logic [15:0] base_addr, in_data, mem_addr, mem_wdata, checksum;
  logic [16:0] word_count;

  risc16_program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .pen        (pen),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .word_count (word_count),
    .checksum   (checksum),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  // Small instance
  logic        s_pen, s_in_valid, s_in_ready, s_mem_wen, s_cpu_hold, s_load_done, s_load_err;
  logic [3:0]  s_base_addr, s_mem_addr;
  logic [15:0] s_in_data, s_mem_wdata, s_checksum;
  logic [4:0]  s_word_count;

  risc16_program_loader #(
    .WORD_LENGTH (16),
    .ADDR_WIDTH  (4),
    .MEM_SIZE    (4)
  ) dut_s (
    .clk        (clk),
    .rst        (rst),
    .pen        (s_pen),
    .base_addr  (s_base_addr),
    .in_valid   (s_in_valid),
    .in_data    (s_in_data),
    .in_ready   (s_in_ready),
    .mem_wen    (s_mem_wen),
    .mem_addr   (s_mem_addr),
    .mem_wdata  (s_mem_wdata),
    .word_count (s_word_count),
    .checksum   (s_checksum),
    .cpu_hold   (s_cpu_hold),
    .load_done  (s_load_done),
    .load_err   (s_load_err)
  );

  // Write/pulse loggers, sampled 1 time unit after each rising edge
  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];
  logic [3:0]  s_wr_addr[$];
  int          done_pulses;

  always @(posedge clk) begin
    #1;
    if (mem_wen) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (s_mem_wen) s_wr_addr.push_back(s_mem_addr);
    if (load_done) done_pulses++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({in_ready, mem_wen, cpu_hold, load_done, load_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {in_ready, mem_wen, cpu_hold, load_done, load_err});
    end
    checks++;
    if ({mem_addr, mem_wdata, word_count, checksum} !== 65'b0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h cnt=%h csum=%h want all 0",
               mem_addr, mem_wdata, word_count, checksum);
    end
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({cpu_hold, in_ready, s_cpu_hold} !== 3'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 000", {cpu_hold, in_ready, s_cpu_hold});
    end
  endtask

  task automatic test_base_load();
    wr_addr.delete();
    wr_data.delete();
    done_pulses = 0;
    pen = 1'b1;
    base_addr = 16'h0010;
    step();
    checks++;
    if ({in_ready, cpu_hold} !== 2'b11) begin
      errors++;
      $display("FAIL base_load_enter: got ready/hold=%b want 11", {in_ready, cpu_hold});
    end
    in_valid = 1'b1;
    in_data = 16'h1111;
    step();
    in_data = 16'h2222;
    step();
    in_data = 16'h4444;
    step();
    in_valid = 1'b0;
    pen = 1'b0;
    step();
    checks++;
    if ({load_done, cpu_hold, in_ready} !== 3'b110) begin
      errors++;
      $display("FAIL base_done_state: got done/hold/ready=%b want 110",
               {load_done, cpu_hold, in_ready});
    end
    step();
    checks++;
    if ({load_done, cpu_hold} !== 2'b00) begin
      errors++;
      $display("FAIL base_after_done: got done/hold=%b want 00", {load_done, cpu_hold});
    end
    checks++;
    if (wr_addr.size() != 3 || wr_addr[0] !== 16'h0010 || wr_addr[1] !== 16'h0011 ||
        wr_addr[2] !== 16'h0012 || wr_data[2] !== 16'h4444) begin
      errors++;
      $display("FAIL base_writes: got %0d writes %p data %p want 3 at 0x10..0x12",
               wr_addr.size(), wr_addr, wr_data);
    end
    checks++;
    if (word_count !== 17'd3 || checksum !== 16'h7777) begin
      errors++;
      $display("FAIL base_totals: got cnt=%0d csum=%h want 3 7777", word_count, checksum);
    end
    checks++;
    if (done_pulses != 1) begin
      errors++;
      $display("FAIL base_done_pulses: got %0d want 1", done_pulses);
    end
  endtask

  task automatic test_stall();
    wr_addr.delete();
    wr_data.delete();
    pen = 1'b1;
    base_addr = 16'h0100;
    step();
    in_valid = 1'b1;
    in_data = 16'hA5A5;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (mem_wen !== 1'b0) begin
      errors++;
      $display("FAIL stall_gap_wen: got %b want 0", mem_wen);
    end
    in_valid = 1'b1;
    in_data = 16'h0F0F;
    step();
    in_valid = 1'b0;
    pen = 1'b0;
    step();
    step();
    checks++;
    if (wr_addr.size() != 2 || wr_addr[1] !== 16'h0101 || wr_data[1] !== 16'h0F0F) begin
      errors++;
      $display("FAIL stall_writes: got %0d writes %p data %p want 2, last 0x101/0F0F",
               wr_addr.size(), wr_addr, wr_data);
    end
    checks++;
    if (word_count !== 17'd2 || checksum !== 16'hAAAA || load_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_totals: got cnt=%0d csum=%h err=%b want 2 AAAA 0",
               word_count, checksum, load_err);
    end
  endtask

  task automatic test_simultaneous();
    pen = 1'b1;
    base_addr = 16'h2000;
    step();
    in_valid = 1'b1;
    in_data = 16'h1234;
    step();
    in_data = 16'h5678;
    pen = 1'b0;
    step();
    in_valid = 1'b0;
    checks++;
    if ({mem_wen, load_done} !== 2'b11 || mem_addr !== 16'h2001 || mem_wdata !== 16'h5678) begin
      errors++;
      $display("FAIL simul_last_write: got wen/done=%b addr=%h data=%h want 11 2001 5678",
               {mem_wen, load_done}, mem_addr, mem_wdata);
    end
    step();
    checks++;
    if (load_done !== 1'b0 || word_count !== 17'd2 || checksum !== 16'h444C) begin
      errors++;
      $display("FAIL simul_totals: got done=%b cnt=%0d csum=%h want 0 2 444C",
               load_done, word_count, checksum);
    end
  endtask

  task automatic test_wrap();
    s_wr_addr.delete();
    s_pen = 1'b1;
    s_base_addr = 4'hE;
    step();
    s_in_valid = 1'b1;
    s_in_data = 16'h0001;
    step();
    s_in_data = 16'h0002;
    step();
    s_in_data = 16'h0003;
    step();
    s_in_valid = 1'b0;
    s_pen = 1'b0;
    step();
    step();
    checks++;
    if (s_wr_addr.size() != 3 || s_wr_addr[0] !== 4'hE || s_wr_addr[1] !== 4'hF ||
        s_wr_addr[2] !== 4'h0) begin
      errors++;
      $display("FAIL wrap_addrs: got %p want E F 0", s_wr_addr);
    end
    checks++;
    if (s_word_count !== 5'd3 || s_checksum !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_totals: got cnt=%0d csum=%h want 3 0000", s_word_count, s_checksum);
    end
  endtask

  task automatic test_overflow();
    bit seen_ready;
    s_wr_addr.delete();
    s_pen = 1'b1;
    s_base_addr = 4'h0;
    step();
    s_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_in_data = 16'h0010 + 16'(i);
      step();
    end
    s_in_valid = 1'b0;
    checks++;
    if ({s_load_err, s_in_ready, s_cpu_hold, s_mem_wen} !== 4'b1010) begin
      errors++;
      $display("FAIL ovf_err_state: got err/ready/hold/wen=%b want 1010",
               {s_load_err, s_in_ready, s_cpu_hold, s_mem_wen});
    end
    checks++;
    if (s_wr_addr.size() != 4 || s_word_count !== 5'd4) begin
      errors++;
      $display("FAIL ovf_writes: got %0d writes cnt=%0d want 4 4", s_wr_addr.size(), s_word_count);
    end
    step();
    checks++;
    if (s_load_err !== 1'b1 || s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_sticky_pen_high: got err=%b ready=%b want 1 0", s_load_err, s_in_ready);
    end
    s_pen = 1'b0;
    step();
    checks++;
    if (s_load_err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky_pen_low: got %b want 1", s_load_err);
    end
    s_pen = 1'b1;
    seen_ready = 1'b0;
    for (int i = 0; i < 5 && !seen_ready; i++) begin
      step();
      seen_ready = s_in_ready;
    end
    checks++;
    if (!seen_ready || s_load_err !== 1'b0 || s_word_count !== 5'd0) begin
      errors++;
      $display("FAIL ovf_restart: got ready_seen=%b err=%b cnt=%0d want 1 0 0",
               seen_ready, s_load_err, s_word_count);
    end
    s_pen = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid_load();
    wr_addr.delete();
    wr_data.delete();
    pen = 1'b1;
    base_addr = 16'h0300;
    step();
    in_valid = 1'b1;
    in_data = 16'hAAAA;
    step();
    in_data = 16'hBBBB;
    step();
    in_data = 16'hCCCC;
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_wen, cpu_hold, load_done, load_err} !== 5'b0 ||
        {mem_addr, mem_wdata, word_count, checksum} !== 65'b0) begin
      errors++;
      $display("FAIL midload_reset: got flags=%b addr=%h wdata=%h cnt=%h csum=%h want all 0",
               {in_ready, mem_wen, cpu_hold, load_done, load_err},
               mem_addr, mem_wdata, word_count, checksum);
    end
    step();
    step();
    checks++;
    if (wr_addr.size() != 2 || mem_wen !== 1'b0) begin
      errors++;
      $display("FAIL midload_no_third: got %0d writes wen=%b want 2 0", wr_addr.size(), mem_wen);
    end
    pen = 1'b0;
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if (cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL midload_idle: got hold=%b want 0", cpu_hold);
    end
  endtask

  initial begin
    rst = 1'b0;
    pen = 1'b0;
    base_addr = '0;
    in_valid = 1'b0;
    in_data = '0;
    s_pen = 1'b0;
    s_base_addr = '0;
    s_in_valid = 1'b0;
    s_in_data = '0;
    done_pulses = 0;
    test_reset();
    test_base_load();
    test_stall();
    test_simultaneous();
    test_wrap();
    test_overflow();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
